uart_tx_serializer: RTL

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_counter.sv | 30 +++
 rtl/uart_tx_serializer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// data width and the idle level of the serial line.
package uart_pkg;

    localparam int  DATA_W     = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last clock of
// every bit period. A clear input holds it at zero while the line is idle.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // Free-running counter that wraps to zero at every bit boundary
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign bit_end = (count == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: 8N1 framing (start, 8 data bits LSB first, stop).
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
// The serial output is registered so nothing combinational reaches the pin.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_rate
            $error("uart_tx_serializer: CLK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_next;
    logic              tx_next;
    logic              done_next;
    logic              clear;
    logic              bit_end;
`ifdef UART_TX_PARITY_EN
    logic              parity_reg;
    logic              parity_next;
`endif

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear),
        .bit_end(bit_end)
    );

    // State, datapath and registered line outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            tx        <= IDLE_LEVEL;
            tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_idx   <= bit_idx_next;
            tx        <= tx_next;
            tx_done   <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // Next-state logic; tx_next is the line level for the coming cycle
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx;
        tx_next      = tx;
        done_next    = 1'b0;
        clear        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        case (state)
            IDLE: begin
                clear   = 1'b1;
                tx_next = IDLE_LEVEL;
                if (tx_start) begin
                    shift_next   = tx_data;
                    bit_idx_next = '0;
                    tx_next      = 1'b0;
                    state_next   = START;
`ifdef UART_TX_PARITY_EN
                    parity_next  = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    tx_next    = shift_reg[0];
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_next    = parity_reg;
                        state_next = PARITY;
`else
                        tx_next    = IDLE_LEVEL;
                        state_next = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shift_next   = shift_reg >> 1;
                        tx_next      = shift_reg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_next    = IDLE_LEVEL;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    tx_next    = IDLE_LEVEL;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                tx_next    = IDLE_LEVEL;
                state_next = IDLE;
            end
        endcase
    end

    assign tx_busy = (state != IDLE);

endmodule
